// File: rtl/bcd_countdown_timer_n.sv
`default_nettype none
// ============================================================================
// Module   : bcd_countdown_timer_n
// Purpose  : N-digit BCD up/down timer with built-in tick prescaler,
//            pause/resume, timeout level/pulse and running status.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer_n #(
  parameter int NUM_DIGITS = 2,
  parameter int TICK_DIV   = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    count_up,
  input  logic                    enable,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    timeout,
  output logic                    timeout_pulse,
  output logic                    running
);

  localparam int            C_W         = 4 * NUM_DIGITS;
  localparam int            C_PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [C_PW-1:0] C_PRESC_MAX = C_PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q;
  logic [C_W-1:0]  digits_q;
  logic [C_W-1:0]  target_q;
  logic            mode_up_q;
  logic [C_PW-1:0] presc_q;
  logic            timeout_q;
  logic            pulse_q;
  logic            running_q;

  logic [C_W-1:0]  w_clamped;
  logic [C_W-1:0]  w_dec;
  logic [C_W-1:0]  w_inc;
  logic [C_W-1:0]  digits_d;
  logic            w_tick_terminal;
  logic            w_load_terminal;

  // Out-of-range nibbles on the load bus are saturated to 9 digit by digit
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_clamp
    assign w_clamped[4*gi +: 4] = (load_value[4*gi +: 4] > 4'd9) ? 4'd9
                                                                 : load_value[4*gi +: 4];
  end

  // Ripple BCD decrement (borrow) and increment (carry) of the current count
  always_comb begin
    logic v_borrow;
    logic v_carry;
    w_dec    = digits_q;
    w_inc    = digits_q;
    v_borrow = 1'b1;
    v_carry  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v_borrow) begin
        if (digits_q[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
          v_borrow        = 1'b0;
        end
      end
      if (v_carry) begin
        if (digits_q[4*i +: 4] >= 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          v_carry         = 1'b0;
        end
      end
    end
  end

  // Count value after a tick and whether that value ends the run
  assign digits_d        = mode_up_q ? w_inc : w_dec;
  assign w_tick_terminal = mode_up_q ? (w_inc == target_q) : (w_dec == '0);
  // A zero load is terminal in both modes (down start 0 or up target 0)
  assign w_load_terminal = (w_clamped == '0);

  // Timer FSM with prescaler; every output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      digits_q  <= '0;
      target_q  <= '0;
      mode_up_q <= 1'b0;
      presc_q   <= '0;
      timeout_q <= 1'b0;
      pulse_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (load) begin
        // Load overrides everything, including a tick due this cycle
        mode_up_q <= count_up;
        presc_q   <= '0;
        running_q <= 1'b0;
        if (count_up) begin
          digits_q <= '0;
          target_q <= w_clamped;
        end else begin
          digits_q <= w_clamped;
        end
        if (w_load_terminal) begin
          state_q   <= S_DONE;
          timeout_q <= 1'b1;
          pulse_q   <= 1'b1;
        end else begin
          state_q   <= S_ARMED;
          timeout_q <= 1'b0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_ARMED: begin
            // Prescaler holds here so a resume finishes the partial period
            if (enable) begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end
          S_RUN: begin
            if (!enable) begin
              state_q   <= S_ARMED;
              running_q <= 1'b0;
            end else if (presc_q == C_PRESC_MAX) begin
              presc_q  <= '0;
              digits_q <= digits_d;
              if (w_tick_terminal) begin
                state_q   <= S_DONE;
                running_q <= 1'b0;
                timeout_q <= 1'b1;
                pulse_q   <= 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_DONE;
          end
          default: begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign digits        = digits_q;
  assign timeout       = timeout_q;
  assign timeout_pulse = pulse_q;
  assign running       = running_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_countdown_timer_n
// Purpose  : Self-checking bench for bcd_countdown_timer_n (2 digits, /4).
//            Directed scenarios followed by randomized traffic, all compared
//            against a decimal-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer_n;

  localparam int ND = 2;
  localparam int TD = 4;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic            clk;
  logic            rst;
  logic            load;
  logic [4*ND-1:0] load_value;
  logic            count_up;
  logic            enable;
  logic [4*ND-1:0] digits;
  logic            timeout;
  logic            timeout_pulse;
  logic            running;

  int n_checks;
  int n_errors;

  // Reference model state: plain decimal count and a phase counter
  int m_st;
  int m_val;
  int m_tgt;
  int m_up;
  int m_phase;
  int m_pulse;

  bcd_countdown_timer_n #(
    .NUM_DIGITS(ND),
    .TICK_DIV  (TD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .load_value   (load_value),
    .count_up     (count_up),
    .enable       (enable),
    .digits       (digits),
    .timeout      (timeout),
    .timeout_pulse(timeout_pulse),
    .running      (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal value of a BCD bus after saturating each nibble to 9
  function automatic int clamp_dec(input logic [4*ND-1:0] v);
    int p;
    int s;
    int n;
    p = 1;
    s = 0;
    for (int i = 0; i < ND; i++) begin
      n = int'(v[4*i +: 4]);
      if (n > 9) n = 9;
      s = s + n * p;
      p = p * 10;
    end
    return s;
  endfunction

  function automatic logic [4*ND-1:0] to_bcd(input int v);
    logic [4*ND-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st    = M_IDLE;
    m_val   = 0;
    m_tgt   = 0;
    m_up    = 0;
    m_phase = 0;
    m_pulse = 0;
  endtask

  // One clock edge of the reference behaviour
  task automatic model_edge(input logic ld, input logic [4*ND-1:0] lv,
                            input logic up, input logic en);
    int c;
    m_pulse = 0;
    if (ld) begin
      c       = clamp_dec(lv);
      m_up    = int'(up);
      m_phase = 0;
      if (up) begin
        m_val = 0;
        m_tgt = c;
      end else begin
        m_val = c;
      end
      if (c == 0) begin
        m_st    = M_DONE;
        m_pulse = 1;
      end else begin
        m_st = M_ARMED;
      end
    end else begin
      case (m_st)
        M_ARMED: if (en) m_st = M_RUN;
        M_RUN: begin
          if (!en) begin
            m_st = M_ARMED;
          end else begin
            m_phase++;
            if (m_phase == TD) begin
              m_phase = 0;
              m_val   = (m_up != 0) ? m_val + 1 : m_val - 1;
              if (m_val == ((m_up != 0) ? m_tgt : 0)) begin
                m_st    = M_DONE;
                m_pulse = 1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".digits"},  32'(digits),        32'(to_bcd(m_val)));
    chk({tag, ".timeout"}, 32'(timeout),       32'(m_st == M_DONE));
    chk({tag, ".pulse"},   32'(timeout_pulse), 32'(m_pulse));
    chk({tag, ".running"}, 32'(running),       32'(m_st == M_RUN));
  endtask

  // Drive one cycle of inputs, advance model at the edge, check 1 ns later
  task automatic step(input logic ld, input logic [4*ND-1:0] lv,
                      input logic up, input logic en);
    load       = ld;
    load_value = lv;
    count_up   = up;
    enable     = en;
    @(posedge clk);
    model_edge(ld, lv, up, en);
    #1;
    check_model("step");
  endtask

  task automatic async_reset_midcycle();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst.digits",  32'(digits),  32'h0);
    chk("arst.timeout", 32'(timeout), 32'h0);
    chk("arst.running", 32'(running), 32'h0);
    chk("arst.pulse",   32'(timeout_pulse), 32'h0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [4*ND-1:0] lv;
    int r;
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    load       = 1'b0;
    load_value = '0;
    count_up   = 1'b0;
    enable     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.digits",  32'(digits),        32'h0);
    chk("reset.timeout", 32'(timeout),       32'h0);
    chk("reset.pulse",   32'(timeout_pulse), 32'h0);
    chk("reset.running", 32'(running),       32'h0);

    // Idle ignores enable
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("idle.running", 32'(running), 32'h0);

    // Down count with borrow
    step(1'b1, 8'h12, 1'b0, 1'b1);
    chk("dn.load", 32'(digits), 32'h12);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dn.run", 32'(running), 32'h1);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dn.11", 32'(digits), 32'h11);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dn.10", 32'(digits), 32'h10);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dn.09", 32'(digits), 32'h09);

    // Load on a tick edge: prescaler sits at 3 after three RUN cycles
    step(1'b1, 8'h12, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h45, 1'b0, 1'b1);
    chk("ldtick.digits", 32'(digits), 32'h45);

    // Clamp of out-of-range nibble
    step(1'b1, 8'hA7, 1'b0, 1'b0);
    chk("clamp.97", 32'(digits), 32'h97);

    // Pause/resume with prescaler at 2
    step(1'b1, 8'h05, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (10) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pause.digits",  32'(digits),  32'h05);
    chk("pause.running", 32'(running), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("resume.running", 32'(running), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("resume.hold", 32'(digits), 32'h05);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("resume.tick", 32'(digits), 32'h04);

    // Down timeout from 0x02 and DONE hold
    step(1'b1, 8'h02, 1'b0, 1'b1);
    for (int k = 0; k < 100 && !timeout_pulse; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dnto.pulse_seen", 32'(timeout_pulse), 32'h1);
    chk("dnto.digits", 32'(digits), 32'h00);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("dnto.pulse_once", 32'(timeout_pulse), 32'h0);
    repeat (20) step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("dnto.hold", 32'(digits), 32'h00);
    chk("dnto.level", 32'(timeout), 32'h1);

    // Load from DONE re-arms
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("redone.timeout", 32'(timeout), 32'h0);

    // Up count with carry to target 0x15
    step(1'b1, 8'h15, 1'b1, 1'b1);
    chk("up.load", 32'(digits), 32'h00);
    for (int k = 0; k < 200 && !timeout_pulse; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("up.pulse_seen", 32'(timeout_pulse), 32'h1);
    chk("up.digits", 32'(digits), 32'h15);
    repeat (8) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("up.hold", 32'(digits), 32'h15);

    // Zero load goes straight to DONE with a pulse
    step(1'b1, 8'h00, 1'b0, 1'b1);
    chk("zero.pulse", 32'(timeout_pulse), 32'h1);
    chk("zero.timeout", 32'(timeout), 32'h1);

    // Async reset mid-prescale, then idle ignores enable
    step(1'b1, 8'h31, 1'b0, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    async_reset_midcycle();
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("postrst.running", 32'(running), 32'h0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 1) == 1) lv = 8'($urandom_range(0, 255));
      else                           lv = 8'($urandom_range(0, 5));
      if (r == 99) begin
        async_reset_midcycle();
        @(negedge clk);
      end else begin
        step(r < 5, lv, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 8);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
